pw_bias_relu_requant: RTL and testbench
=======================================

Name: pw_bias_relu_requant

Overview:
- Post-accumulation stage for the depthwise-pointwise layer-3 path.
- Consumes the signed pointwise MAC accumulator stream, one sample per output channel, and tracks the channel index.
- Drives the 7-bit address of the layer's combinational 8-bit bias ROM and adds the returned bias.
- Applies ReLU, requantizes by arithmetic right shift and saturates to unsigned 7-bit range in an 8-bit output, for the next layer's line buffer.

Parameters:
- ACC_W, 20, accumulator width (signed two's complement).
- NUM_CH, 128, output channels per pixel; must be ≤128.
- BIAS_LSH, 4, left shift aligning the int8 bias to the accumulator scale.
- SHIFT, 4, requantization right shift (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  accumulator sample valid.
- in_ready  out  1  stage can accept a sample.
- in_acc  in  ACC_W  signed accumulator.
- in_last  in  1  marks the last channel of the current pixel.
- bias_addr  out  7  bias ROM address; equals the current channel counter.
- bias_data  in  8  signed bias from ROM, combinational on bias_addr.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  result, 0..127.
- out_ch  out  7  channel index of out_data.
- out_last  out  1  in_last delayed with the data.
- err_align  out  1  sticky in_last/channel mismatch flag.

Behaviour:
- **Reset (sync, rst=1 at posedge):**
  - ch counter = 0.
  - Both pipeline valids = 0.
  - out_valid = 0, out_data = 0, out_ch = 0, out_last = 0, err_align = 0.
  - bias_addr follows ch, so it reads 0.
  - Reset mid-stream drops all in-flight samples, with no output for them.
- **Pipeline enable:** en = !out_valid || out_ready.
  - in_ready = en.
  - Both stages advance only when en=1 (global stall).
  - Accept = in_valid && in_ready.
- **Stage 1, on accept:**
  - Register sum = sext(in_acc) + (sext(bias_data) << BIAS_LSH), width ACC_W+BIAS_LSH+9 so it cannot overflow.
  - Register ch, in_last and valid.
  - bias_data is sampled in the same cycle bias_addr=ch.
- **Stage 2:**
  - If sum ≤ 0, result = 0 (ReLU).
  - Otherwise q = sum >>> SHIFT (see Optional Feature), and result = min(q, 127).
  - Register into out_data, out_ch, out_last, out_valid.
- **Latency:** 2 cycles from accept to out_valid with no stall; throughput 1/cycle.
- **Output hold:** when out_valid=1 and out_ready=0, all outputs hold stable and in_ready=0.
- **Bubbles:** if enabled with no input, the stage-1 valid becomes 0 and bubbles propagate.
- **Channel counter:** advances on accept.
  - If in_last=1, ch is forced to 0.
  - Else if ch==NUM_CH-1, ch wraps to 0.
  - Else ch increments by 1.
- **Alignment errors (err_align set to 1):**
  - in_last=1 while ch≠NUM_CH-1.
  - in_last=0 while ch==NUM_CH-1 (counter still wraps).
  - The sample is processed normally in both cases.
  - err_align clears only on rst.

Optional Feature:
- Macro: PW_BIAS_ROUND_EN.
- **Defined:** q = (sum + (1 << (SHIFT-1))) >>> SHIFT, i.e. round half up. Rounding applies only to positive sums, before the 127 clamp.
- **Undefined:** q = sum >>> SHIFT (truncation).
- ReLU, saturation and latency are identical in both builds.

Test Plan:
- **Basic:** bias stub returns 8'ha6 (−90) at addr 0; in_acc=2000 at ch 0 → sum=560 → out_data=35 (35 in both builds), out_ch=0, out_valid 2 cycles after accept.
- **ReLU and saturation:**
  - in_acc=0 with bias 8'ha6 → out_data=0.
  - in_acc=4000 with bias 8'h09 → sum=4144 → q=259 → out_data=127.
- **Rounding:** bias 8'h00, in_acc=24 → out_data=1 when PW_BIAS_ROUND_EN is undefined, 2 when defined. in_acc=−24 → 0 in both builds.
- **Backpressure:** stream of 10 samples with out_ready held low 3 cycles mid-stream → out_data/out_ch stable while stalled, in_ready=0, no loss or duplication, order preserved.
- **Wrap:**
  - 256 samples with in_last on ch 127 and 255 → bias_addr and out_ch sequence 0..127, 0..127; out_last on the 128th and 256th outputs; err_align=0.
  - Without in_last, the counter still wraps and err_align=1.
- **Misalignment and reset:**
  - in_last at ch 5 → err_align=1 and the next sample uses ch 0.
  - Asserting rst with 2 samples in flight → out_valid=0 the next cycle, ch=0 and err_align=0.

Source files
------------

// File: rtl/pw_bias_relu_requant.sv
// Bias add, ReLU, requantize and 7-bit saturate for the layer-3 pointwise accumulator stream; 2-cycle latency, 1 sample/cycle.
// Global stall: both stages freeze while out_valid && !out_ready, which also drops in_ready. PW_BIAS_ROUND_EN selects round-half-up.
module pw_bias_relu_requant #(
    parameter int ACC_W    = 20,
    parameter int NUM_CH   = 128,
    parameter int BIAS_LSH = 4,
    parameter int SHIFT    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_acc,
    input  logic                    in_last,
    output logic [6:0]              bias_addr,
    input  logic [7:0]              bias_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic [6:0]              out_ch,
    output logic                    out_last,
    output logic                    err_align
);

    localparam int SUM_W = ACC_W + BIAS_LSH + 9;
    localparam logic [6:0] LAST_CH = 7'(NUM_CH - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(127);

    logic                    en;
    logic                    accept;
    logic [6:0]              ch;
    logic                    s1_vld;
    logic                    s1_last;
    logic [6:0]              s1_ch;
    logic signed [SUM_W-1:0] s1_sum;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] bias_ext;
    logic signed [SUM_W-1:0] sum_next;
    logic signed [SUM_W-1:0] q;
    logic                    non_pos;
    logic [7:0]              res;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign accept    = in_valid && en;
    assign bias_addr = ch;

    // Sum is wide enough that acc + shifted bias can never overflow.
    always_comb begin
        acc_ext  = {{(SUM_W-ACC_W){in_acc[ACC_W-1]}}, in_acc};
        bias_ext = {{(SUM_W-8){bias_data[7]}}, bias_data} <<< BIAS_LSH;
        sum_next = acc_ext + bias_ext;
    end

    always_comb begin
`ifdef PW_BIAS_ROUND_EN
        q = (s1_sum + SUM_W'(1 << (SHIFT - 1))) >>> SHIFT;
`else
        q = s1_sum >>> SHIFT;
`endif
        non_pos = s1_sum[SUM_W-1] || (s1_sum == '0);
        if (non_pos) begin
            res = 8'd0;
        end else if (q > SAT_MAX) begin
            res = 8'd127;
        end else begin
            res = {1'b0, q[6:0]};
        end
    end

    // Channel counter and sticky alignment check; in_last always resyncs to channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch        <= 7'd0;
            err_align <= 1'b0;
        end else if (accept) begin
            if (in_last != (ch == LAST_CH)) begin
                err_align <= 1'b1;
            end
            if (in_last || (ch == LAST_CH)) begin
                ch <= 7'd0;
            end else begin
                ch <= ch + 7'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_sum  <= '0;
            s1_ch   <= 7'd0;
            s1_last <= 1'b0;
        end else if (en) begin
            s1_vld <= accept;
            if (accept) begin
                s1_sum  <= sum_next;
                s1_ch   <= ch;
                s1_last <= in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_ch    <= 7'd0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_data <= res;
                out_ch   <= s1_ch;
                out_last <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_pw_bias_relu_requant.sv
// Directed bench for pw_bias_relu_requant with a combinational bias ROM stub.
module tb_pw_bias_relu_requant;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_acc;
    logic        in_last;
    logic [6:0]  bias_addr;
    logic [7:0]  bias_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [6:0]  out_ch;
    logic        out_last;
    logic        err_align;

    logic [7:0]  bias_rom [0:127];

    int checks;
    int failures;

    pw_bias_relu_requant dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_acc   (in_acc),
        .in_last  (in_last),
        .bias_addr(bias_addr),
        .bias_data(bias_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_last (out_last),
        .err_align(err_align)
    );

    assign bias_data = bias_rom[bias_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias scaled by 16, ReLU, shift by 4, clamp to 127.
    function automatic logic [7:0] model(input int acc, input logic [7:0] b);
        int sb;
        int s;
        int q;
        sb = $signed(b);
        s  = acc + sb * 16;
        if (s <= 0) return 8'd0;
`ifdef PW_BIAS_ROUND_EN
        q = (s + 8) >>> 4;
`else
        q = s >>> 4;
`endif
        if (q > 127) return 8'd127;
        return 8'(q);
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_acc    = 20'd0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || out_ch !== 7'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b data=%0d ch=%0d last=%b, need 0/0/0/0",
                     out_valid, out_data, out_ch, out_last);
        end
        checks++;
        if (err_align !== 1'b0 || bias_addr !== 7'd0) begin
            failures++;
            $display("FAIL reset_state: err=%b addr=%0d, need 0/0", err_align, bias_addr);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        bias_rom[0] = 8'ha6;
        in_valid = 1'b1;
        in_acc   = 20'd2000;
        in_last  = 1'b0;
        #1;
        checks++;
        if (bias_addr !== 7'd0) begin
            failures++;
            $display("FAIL basic_addr: got %0d need 0", bias_addr);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: got %b need 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd35 || out_ch !== 7'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: valid=%b data=%0d ch=%0d last=%b, need 1/35/0/0",
                     out_valid, out_data, out_ch, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_bubble: got %b need 0", out_valid);
        end
    endtask

    task automatic test_relu_sat();
        do_reset();
        bias_rom[0] = 8'ha6;
        bias_rom[1] = 8'h09;
        in_valid = 1'b1;
        in_acc   = 20'd0;
        tick();
        in_acc = 20'd4000;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd0 || out_ch !== 7'd0) begin
            failures++;
            $display("FAIL relu_zero: valid=%b data=%0d ch=%0d, need 1/0/0", out_valid, out_data, out_ch);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd127 || out_ch !== 7'd1) begin
            failures++;
            $display("FAIL saturate: valid=%b data=%0d ch=%0d, need 1/127/1", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_round();
        logic [7:0] exp_pos;
`ifdef PW_BIAS_ROUND_EN
        exp_pos = 8'd2;
`else
        exp_pos = 8'd1;
`endif
        do_reset();
        bias_rom[0] = 8'h00;
        bias_rom[1] = 8'h00;
        in_valid = 1'b1;
        in_acc   = 20'd24;
        tick();
        in_acc = -20'sd24;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_pos) begin
            failures++;
            $display("FAIL round_pos: valid=%b data=%0d, need 1/%0d", out_valid, out_data, exp_pos);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd0) begin
            failures++;
            $display("FAIL round_neg: valid=%b data=%0d, need 1/0", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int recv;
        logic held;
        logic [7:0] hd;
        logic [6:0] hc;
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < 10; i++) bias_rom[i] = 8'(i * 9 - 40);
        sent = 0;
        recv = 0;
        held = 1'b0;
        hd = 8'd0;
        hc = 7'd0;
        for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 8);
            in_valid  = (sent < 10);
            in_acc    = 20'(sent * 250 - 300);
            in_last   = 1'b0;
            #3;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== hd || out_ch !== hc) begin
                    failures++;
                    $display("FAIL bp_hold: valid=%b data=%0d ch=%0d, need 1/%0d/%0d",
                             out_valid, out_data, out_ch, hd, hc);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready: got %b need 0", in_ready);
                end
                held = 1'b1;
                hd = out_data;
                hc = out_ch;
            end else begin
                held = 1'b0;
            end
            if (out_valid && out_ready) begin
                exp_d = model(recv * 250 - 300, bias_rom[recv]);
                checks++;
                if (out_data !== exp_d || out_ch !== 7'(recv)) begin
                    failures++;
                    $display("FAIL bp_data[%0d]: data=%0d ch=%0d, need %0d/%0d",
                             recv, out_data, out_ch, exp_d, recv);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (sent != 10 || recv != 10) begin
            failures++;
            $display("FAIL bp_count: sent=%0d recv=%0d, need 10/10", sent, recv);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_extra: out_valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        int sent;
        int recv;
        do_reset();
        for (int i = 0; i < 128; i++) bias_rom[i] = 8'h00;
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 400 && recv < 256; cyc++) begin
            in_valid = (sent < 256);
            in_acc   = 20'((sent % 128) * 16);
            in_last  = (sent == 127) || (sent == 255);
            #3;
            if (in_valid && in_ready) begin
                checks++;
                if (bias_addr !== 7'(sent % 128)) begin
                    failures++;
                    $display("FAIL wrap_addr[%0d]: got %0d need %0d", sent, bias_addr, sent % 128);
                end
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_ch !== 7'(recv % 128) || out_data !== 8'(recv % 128) ||
                    out_last !== ((recv % 128) == 127)) begin
                    failures++;
                    $display("FAIL wrap_out[%0d]: ch=%0d data=%0d last=%b, need %0d/%0d/%b",
                             recv, out_ch, out_data, out_last, recv % 128, recv % 128,
                             (recv % 128) == 127);
                end
                recv++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (recv != 256 || err_align !== 1'b0) begin
            failures++;
            $display("FAIL wrap_aligned: recv=%0d err=%b, need 256/0", recv, err_align);
        end

        do_reset();
        sent = 0;
        for (int cyc = 0; cyc < 200 && sent < 130; cyc++) begin
            in_valid = 1'b1;
            in_acc   = 20'd16;
            in_last  = 1'b0;
            #3;
            if (in_ready) begin
                checks++;
                if (bias_addr !== 7'(sent % 128)) begin
                    failures++;
                    $display("FAIL wrap_nolast_addr[%0d]: got %0d need %0d", sent, bias_addr, sent % 128);
                end
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 130 || err_align !== 1'b1) begin
            failures++;
            $display("FAIL wrap_nolast_err: sent=%0d err=%b, need 130/1", sent, err_align);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin
                checks++;
                if (err_align !== 1'b0) begin
                    failures++;
                    $display("FAIL mis_pre_err: got %b need 0", err_align);
                end
            end
            in_valid = 1'b1;
            in_acc   = 20'd160;
            in_last  = (k == 5);
            tick();
        end
        checks++;
        if (err_align !== 1'b1 || bias_addr !== 7'd0) begin
            failures++;
            $display("FAIL mis_err: err=%b addr=%0d, need 1/0", err_align, bias_addr);
        end
        in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 7'd5 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL mis_last_out: valid=%b ch=%0d last=%b, need 1/5/1", out_valid, out_ch, out_last);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 7'd0 || out_last !== 1'b0 || out_data !== 8'd10) begin
            failures++;
            $display("FAIL mis_next_ch: valid=%b ch=%0d last=%b data=%0d, need 1/0/0/10",
                     out_valid, out_ch, out_last, out_data);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        in_valid = 1'b1;
        in_acc   = 20'd500;
        in_last  = 1'b1;
        tick();
        in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (err_align !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: err=%b valid=%b, need 1/1", err_align, out_valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || err_align !== 1'b0 || bias_addr !== 7'd0) begin
            failures++;
            $display("FAIL rst_flush: valid=%b err=%b addr=%0d, need 0/0/0", out_valid, err_align, bias_addr);
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_dropped: valid=%b need 0", out_valid);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_acc    = 20'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 128; i++) bias_rom[i] = 8'h00;
        test_reset();
        test_basic();
        test_relu_sat();
        test_round();
        test_backpressure();
        test_wrap();
        test_misalign();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
